// File: rtl/mult_share_pkg.sv
// ============================================================================
// Module   : mult_share_pkg
// Brief    : Shared widths and operand/product types for the shared multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_share_pkg;

    localparam int MUL_AW   = 18;
    localparam int MUL_PW   = 36;
    localparam int NREQ_MAX = 8;

    typedef logic signed [MUL_AW-1:0] mul_opnd_t;
    typedef logic signed [MUL_PW-1:0] mul_prod_t;

endpackage

`default_nettype wire

// File: rtl/mult_share_arb_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin pick: first request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_v
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest asserted request wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        gnt_v  = 1'b0;
        idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
                gnt_v    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_share_arb.sv
// ============================================================================
// Module   : mult_share_arb
// Brief    : Round-robin sharing of one registered 18x18 signed multiplier.
//            Optional response register stage: MULT_SHARE_ARB_OUTREG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*MUL_AW-1:0] req_a,
    input  logic [NREQ*MUL_AW-1:0] req_b,
    output logic                   mul_en,
    output logic [MUL_AW-1:0]      mul_a,
    output logic [MUL_AW-1:0]      mul_b,
    input  logic [MUL_PW-1:0]      mul_p,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [MUL_PW-1:0]      rsp_p
);

    logic [IDW-1:0]  rr_ptr;
    logic            iss_v;
    logic [IDW-1:0]  iss_id;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_v;
    mul_opnd_t       opa [NREQ];
    mul_opnd_t       opb [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign opa[i] = req_a[MUL_AW*i +: MUL_AW];
        assign opb[i] = req_b[MUL_AW*i +: MUL_AW];
    end

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .gnt_v  (gnt_v)
    );

    assign req_ready = gnt;
    assign mul_en    = |req_valid;
    assign mul_a     = gnt_v ? opa[gnt_id] : '0;
    assign mul_b     = gnt_v ? opb[gnt_id] : '0;

    // Explicit wrap keeps the pointer in range when NREQ is not a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            iss_v  <= 1'b0;
            iss_id <= '0;
        end else begin
            iss_v <= gnt_v;
            if (gnt_v) begin
                rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                iss_id <= gnt_id;
            end
        end
    end

`ifdef MULT_SHARE_ARB_OUTREG_EN
    logic           rsp_v_q;
    logic [IDW-1:0] rsp_id_q;
    mul_prod_t      rsp_p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_v_q  <= 1'b0;
            rsp_id_q <= '0;
            rsp_p_q  <= '0;
        end else begin
            rsp_v_q  <= iss_v;
            rsp_id_q <= iss_id;
            rsp_p_q  <= mul_p;
        end
    end

    assign rsp_valid = rsp_v_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
`else
    assign rsp_valid = iss_v;
    assign rsp_id    = iss_id;
    assign rsp_p     = mul_p;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arb.sv
// ============================================================================
// Module   : tb_mult_share_arb
// Brief    : Self-checking bench for mult_share_arb with a multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_share_arb;

`ifdef MULT_SHARE_ARB_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [71:0] req_a = '0;
    logic [71:0] req_b = '0;
    logic        mul_en;
    logic [17:0] mul_a;
    logic [17:0] mul_b;
    logic [35:0] mul_p = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [35:0] rsp_p;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mult_share_arb #(.NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p)
    );

    // Registered DSP multiplier: one-cycle latency, holds while mul_en is low.
    always @(posedge clk) begin
        if (mul_en) mul_p <= $signed(mul_a) * $signed(mul_b);
    end

    // Reference model: pointer plus a cycle-indexed table of expected responses.
    int          m_ptr = 0;
    int          cyc = 0;
    bit          ev  [1024];
    int          eid [1024];
    logic [35:0] ep  [1024];

    logic [3:0]  e_gnt;
    int          e_gid;
    bit          e_gv;
    logic [17:0] e_a, e_b;
    bit          e_rv;
    int          e_rid;
    logic [35:0] e_rp;

    task automatic set_op(input int i, input int a, input int b);
        req_a[18*i +: 18] = 18'(a);
        req_b[18*i +: 18] = 18'(b);
    endtask

    task automatic apply(input logic [3:0] v);
        int slot;
        req_valid = v;
        #1;
        e_gv  = 1'b0;
        e_gid = 0;
        e_gnt = '0;
        for (int k = 0; k < N; k++) begin
            if (!e_gv && v[(m_ptr + k) % N]) begin
                e_gv  = 1'b1;
                e_gid = (m_ptr + k) % N;
            end
        end
        if (e_gv) e_gnt[e_gid] = 1'b1;
        e_a   = e_gv ? req_a[18*e_gid +: 18] : 18'd0;
        e_b   = e_gv ? req_b[18*e_gid +: 18] : 18'd0;
        slot  = cyc % 1024;
        e_rv  = ev[slot];
        e_rid = eid[slot];
        e_rp  = ep[slot];
    endtask

    task automatic commit();
        int s;
        longint prod;
        if (e_gv) begin
            s      = (cyc + LAT) % 1024;
            prod   = longint'($signed(e_a)) * longint'($signed(e_b));
            ev[s]  = 1'b1;
            eid[s] = e_gid;
            ep[s]  = prod[35:0];
            m_ptr  = (e_gid + 1) % N;
        end
        ev[cyc % 1024] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        m_ptr     = 0;
        for (int i = 0; i < 1024; i++) ev[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        apply(4'b0000);
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        vectors++; if (rsp_id !== 2'd0) begin miscompares++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        vectors++; if (mul_en !== 1'b0 || mul_a !== 18'd0) begin miscompares++; $display("FAIL reset_mul got en=%b a=%h want en=0 a=0", mul_en, mul_a); end
        vectors++; if (dut.rr_ptr !== 2'd0) begin miscompares++; $display("FAIL reset_ptr got %0d want 0", dut.rr_ptr); end
        commit();
    endtask

    task automatic test_single();
        do_reset();
        set_op(0, 3, -5);
        for (int k = 0; k <= LAT; k++) begin
            apply(k == 0 ? 4'b0001 : 4'b0000);
            if (k == 0) begin
                vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL single_ready got %b want 0001", req_ready); end
                vectors++; if (mul_a !== 18'd3 || mul_b !== 18'h3FFFB) begin miscompares++; $display("FAIL single_ops got %h,%h want 00003,3fffb", mul_a, mul_b); end
            end
            vectors++; if (rsp_valid !== (k == LAT)) begin miscompares++; $display("FAIL single_rsp_valid k=%0d got %b want %b", k, rsp_valid, k == LAT); end
            if (k == LAT) begin
                vectors++; if (rsp_id !== 2'd0 || rsp_p !== 36'hF_FFFF_FFF1) begin miscompares++; $display("FAIL single_rsp got id=%0d p=%h want id=0 p=ffffffff1", rsp_id, rsp_p); end
            end
            commit();
        end
        vectors++; if (dut.rr_ptr !== 2'd1) begin miscompares++; $display("FAIL single_ptr got %0d want 1", dut.rr_ptr); end
    endtask

    task automatic test_back_to_back();
        int g;
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, i + 1, 10);
        for (int k = 0; k < 8 + LAT; k++) begin
            apply(k < 8 ? 4'b1111 : 4'b0000);
            if (k < 8) begin
                vectors++; if (req_ready !== (4'b0001 << (k % 4))) begin miscompares++; $display("FAIL b2b_ready k=%0d got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
            end
            vectors++; if (rsp_valid !== (k >= LAT)) begin miscompares++; $display("FAIL b2b_rsp_valid k=%0d got %b want %b", k, rsp_valid, k >= LAT); end
            if (k >= LAT) begin
                g = (k - LAT) % 4;
                vectors++; if (rsp_id !== 2'(g) || rsp_p !== 36'(10 * (g + 1))) begin miscompares++; $display("FAIL b2b_rsp k=%0d got id=%0d p=%0d want id=%0d p=%0d", k, rsp_id, rsp_p, g, 10 * (g + 1)); end
            end
            commit();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_op(0, 7, 2);
        apply(4'b0001);
        commit();
        set_op(2, -4, 9);
        apply(4'b0101);
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL wrap_first got %b want 0100", req_ready); end
        commit();
        apply(4'b0001);
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL wrap_second got %b want 0001", req_ready); end
        commit();
        vectors++; if (dut.rr_ptr !== 2'd1) begin miscompares++; $display("FAIL wrap_ptr got %0d want 1", dut.rr_ptr); end
        for (int k = 0; k < LAT + 1; k++) begin
            apply(4'b0000);
            vectors++; if (rsp_valid !== e_rv) begin miscompares++; $display("FAIL wrap_rsp_valid got %b want %b", rsp_valid, e_rv); end
            if (e_rv) begin
                vectors++; if (rsp_id !== 2'(e_rid) || rsp_p !== e_rp) begin miscompares++; $display("FAIL wrap_rsp got id=%0d p=%h want id=%0d p=%h", rsp_id, rsp_p, e_rid, e_rp); end
            end
            commit();
        end
    endtask

    task automatic test_corner();
        logic [35:0] want;
        set_op(1, -131072, -131072);
        set_op(3, 131071, -131072);
        for (int k = 0; k < LAT + 2; k++) begin
            apply(k == 0 ? 4'b0010 : (k == 1 ? 4'b1000 : 4'b0000));
            if (e_rv) begin
                want = (e_rid == 1) ? 36'h4_0000_0000 : 36'hC_0002_0000;
                vectors++; if (rsp_valid !== 1'b1 || rsp_p !== want) begin miscompares++; $display("FAIL corner_p id=%0d got v=%b p=%h want p=%h", e_rid, rsp_valid, rsp_p, want); end
            end
            commit();
        end
    endtask

    task automatic test_idle();
        int ptr0;
        ptr0 = m_ptr;
        for (int k = 0; k < LAT + 1; k++) begin
            apply(4'b0000);
            vectors++; if (mul_en !== 1'b0 || req_ready !== 4'b0000 || mul_a !== 18'd0) begin miscompares++; $display("FAIL idle_mul got en=%b rdy=%b a=%h want 0", mul_en, req_ready, mul_a); end
            vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL idle_rsp_valid got %b want 0", rsp_valid); end
            commit();
        end
        vectors++; if (dut.rr_ptr !== 2'(ptr0)) begin miscompares++; $display("FAIL idle_ptr got %0d want %0d", dut.rr_ptr, ptr0); end
    endtask

    task automatic test_reset_mid();
        set_op(2, 5, 6);
        apply(4'b0100);
        commit();
        rst_n = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_async got %b want 0", rsp_valid); end
        do_reset();
        for (int k = 0; k < LAT + 1; k++) begin
            apply(4'b0000);
            vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_rsp_valid k=%0d got %b want 0", k, rsp_valid); end
            commit();
        end
        apply(4'b1111);
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL midrst_ptr got %b want 0001", req_ready); end
        commit();
        for (int k = 0; k < LAT; k++) begin
            apply(4'b0000);
            commit();
        end
    endtask

    task automatic test_random();
        int a, b;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                a = ($urandom_range(0, 7) == 0) ? -131072 : $urandom_range(0, 262143) - 131072;
                b = ($urandom_range(0, 7) == 0) ? 131071 : $urandom_range(0, 262143) - 131072;
                set_op(i, a, b);
            end
            apply(k >= 396 ? 4'b0000 : 4'($urandom_range(0, 15)));
            vectors++; if (req_ready !== e_gnt) begin miscompares++; $display("FAIL rnd_ready k=%0d got %b want %b", k, req_ready, e_gnt); end
            vectors++; if (mul_en !== (req_valid != 4'b0000)) begin miscompares++; $display("FAIL rnd_mul_en k=%0d got %b", k, mul_en); end
            vectors++; if (mul_a !== e_a || mul_b !== e_b) begin miscompares++; $display("FAIL rnd_ops k=%0d got %h,%h want %h,%h", k, mul_a, mul_b, e_a, e_b); end
            vectors++; if (rsp_valid !== e_rv) begin miscompares++; $display("FAIL rnd_rsp_valid k=%0d got %b want %b", k, rsp_valid, e_rv); end
            if (e_rv) begin
                vectors++; if (rsp_id !== 2'(e_rid) || rsp_p !== e_rp) begin miscompares++; $display("FAIL rnd_rsp k=%0d got id=%0d p=%h want id=%0d p=%h", k, rsp_id, rsp_p, e_rid, e_rp); end
            end
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_corner();
        test_idle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
